// File: rtl/mem_access_unit_if.sv
//------------------------------------------------------------------------------
// mem_access_unit_if : request, memory-port and response bundle of mem_access_unit
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface mem_access_unit_if #(
  parameter int N = 32,
  parameter int V = 256
);
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic         req_vector;
  logic [N-1:0] req_addr;
  logic [V-1:0] req_wdata;

  logic [N-1:0] mem_address;
  logic [31:0]  mem_byteena;
  logic [V-1:0] mem_wdata;
  logic         mem_rden;
  logic         mem_wren;
  logic [V-1:0] mem_rdata;

  logic         rsp_valid;
  logic [V-1:0] rsp_rdata;
  logic         rsp_err;

  // Unit side: serves requests and drives the memory port.
  modport slave (
    input  req_valid, req_write, req_vector, req_addr, req_wdata, mem_rdata,
    output req_ready, mem_address, mem_byteena, mem_wdata, mem_rden, mem_wren,
    output rsp_valid, rsp_rdata, rsp_err
  );

  // Pipeline and memory side.
  modport master (
    output req_valid, req_write, req_vector, req_addr, req_wdata, mem_rdata,
    input  req_ready, mem_address, mem_byteena, mem_wdata, mem_rden, mem_wren,
    input  rsp_valid, rsp_rdata, rsp_err
  );
endinterface

`default_nettype wire

// File: rtl/mem_access_unit.sv
//------------------------------------------------------------------------------
// mem_access_unit : scalar/vector load-store requester for a 256-bit line memory
// Optional feature macro: MAU_SPLIT_ACCESS_EN (line-crossing accesses as two beats)
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_access_unit #(
  parameter int N = 32,
  parameter int V = 256
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_unit_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ACC0 = 3'd1,
    ACC1 = 3'd2,
    CAP  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t       state, state_nx;
  logic [N-1:0] addr_q;
  logic         write_q;
  logic         vector_q;
  logic         err_q;
  logic [V-1:0] wdata_q;
  logic [V-1:0] beat0_q;
  logic [V-1:0] rdata_q;

  logic [4:0]     off;
  logic [7:0]     bit_off;
  logic [N-6:0]   line0, line1;
  logic           split;
  logic [63:0]    mask64;
  logic [V-1:0]   wdata_m;
  logic [2*V-1:0] data2x;
  logic [2*V-1:0] rd2x;
  logic [V-1:0]   rd_shift;
  logic [V-1:0]   load_result;
  logic           accept;
`ifndef MAU_SPLIT_ACCESS_EN
  logic           req_split;
`endif

  assign off     = addr_q[4:0];
  assign bit_off = {off, 3'b000};
  assign line0   = addr_q[N-1:5];
  assign line1   = line0 + {{(N-6){1'b0}}, 1'b1};
  assign split   = vector_q ? (off != 5'd0) : (off > 5'd28);
  assign accept  = (state == IDLE) && bus.req_valid;

`ifndef MAU_SPLIT_ACCESS_EN
  assign req_split = bus.req_vector ? (bus.req_addr[4:0] != 5'd0) : (bus.req_addr[4:0] > 5'd28);
`endif

  // Enables and data for both beats come from one 64-lane / 512-bit shifted image.
  assign mask64  = (vector_q ? 64'h0000_0000_FFFF_FFFF : 64'h0000_0000_0000_000F) << off;
  assign wdata_m = vector_q ? wdata_q : {{(V-32){1'b0}}, wdata_q[31:0]};
  assign data2x  = {{V{1'b0}}, wdata_m} << bit_off;

  // The final beat arrives on mem_rdata during CAP; beat0 was captured in ACC1 for splits.
  assign rd2x        = split ? {bus.mem_rdata, beat0_q} : {{V{1'b0}}, bus.mem_rdata};
  assign rd_shift    = V'(rd2x >> bit_off);
  assign load_result = vector_q ? rd_shift : {{(V-32){1'b0}}, rd_shift[31:0]};

  assign bus.rsp_rdata = rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      addr_q   <= '0;
      write_q  <= 1'b0;
      vector_q <= 1'b0;
      err_q    <= 1'b0;
      wdata_q  <= '0;
      beat0_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        addr_q   <= bus.req_addr;
        write_q  <= bus.req_write;
        vector_q <= bus.req_vector;
        wdata_q  <= bus.req_wdata;
`ifdef MAU_SPLIT_ACCESS_EN
        err_q    <= 1'b0;
`else
        err_q    <= req_split;
`endif
      end
      if (state == ACC1 && !write_q) beat0_q <= bus.mem_rdata;
      if (state == CAP) rdata_q <= load_result;
    end
  end

  always_comb begin
    state_nx        = state;
    bus.req_ready   = 1'b0;
    bus.mem_address = '0;
    bus.mem_byteena = '0;
    bus.mem_wdata   = '0;
    bus.mem_rden    = 1'b0;
    bus.mem_wren    = 1'b0;
    bus.rsp_valid   = 1'b0;
    bus.rsp_err     = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
`ifdef MAU_SPLIT_ACCESS_EN
          state_nx = ACC0;
`else
          state_nx = req_split ? DONE : ACC0;
`endif
        end
      end
      ACC0: begin
        bus.mem_address = {{5{1'b0}}, line0};
        bus.mem_rden    = !write_q;
        bus.mem_wren    = write_q;
        if (write_q) begin
          bus.mem_byteena = mask64[31:0];
          bus.mem_wdata   = data2x[V-1:0];
        end
        if (split)         state_nx = ACC1;
        else if (!write_q) state_nx = CAP;
        else               state_nx = DONE;
      end
      ACC1: begin
        bus.mem_address = {{5{1'b0}}, line1};
        bus.mem_rden    = !write_q;
        bus.mem_wren    = write_q;
        if (write_q) begin
          bus.mem_byteena = mask64[63:32];
          bus.mem_wdata   = data2x[2*V-1:V];
        end
        state_nx = write_q ? DONE : CAP;
      end
      CAP: begin
        state_nx = DONE;
      end
      DONE: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_err   = err_q;
        state_nx      = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
//------------------------------------------------------------------------------
// tb_mem_access_unit : randomized check of mem_access_unit against a byte-array model
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_mem_access_unit;
  localparam int N     = 32;
  localparam int V     = 256;
  localparam int LINES = 16;
  localparam int BYTES = LINES * 32;
`ifdef MAU_SPLIT_ACCESS_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_access_unit_if #(.N(N), .V(V)) bus ();
  mem_access_unit #(.N(N), .V(V)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [N-1:0] a;
    logic [31:0]  be;
    logic [V-1:0] d;
    logic         w;
  } beat_t;

  logic [V-1:0] mem_lines [LINES];
  logic [7:0]   ref_mem [BYTES];
  logic [V-1:0] last_load;
  beat_t        beats [$];
  int           total = 0;
  int           bad   = 0;

  // Line memory seen by the DUT; the byte array ref_mem is the independent model.
  always @(posedge clk) begin
    if (bus.mem_rden || bus.mem_wren)
      beats.push_back('{bus.mem_address, bus.mem_byteena, bus.mem_wdata, bus.mem_wren});
    if (bus.mem_rden) bus.mem_rdata <= mem_lines[bus.mem_address[3:0]];
    if (bus.mem_wren)
      for (int k = 0; k < 32; k++)
        if (bus.mem_byteena[k]) mem_lines[bus.mem_address[3:0]][8*k +: 8] <= bus.mem_wdata[8*k +: 8];
  end

  task automatic check(input string tag, input logic [V-1:0] got, input logic [V-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [V-1:0] ref_load(input logic [N-1:0] a, input bit vec);
    logic [V-1:0] r;
    int sz;
    r  = '0;
    sz = vec ? 32 : 4;
    for (int i = 0; i < sz; i++) r[8*i +: 8] = ref_mem[(int'(a[8:0]) + i) % BYTES];
    return r;
  endfunction

  // limit = number of leading bytes that actually reach memory.
  task automatic ref_store(input logic [N-1:0] a, input bit vec, input logic [V-1:0] wd, input int limit);
    int sz;
    sz = vec ? 32 : 4;
    for (int i = 0; i < sz && i < limit; i++) ref_mem[(int'(a[8:0]) + i) % BYTES] = wd[8*i +: 8];
  endtask

  task automatic do_req(input bit wr, input bit vec, input logic [N-1:0] a, input logic [V-1:0] wd);
    bit sp, err;
    int exp_lat, exp_beats, lat, nwr;
    sp        = vec ? (a[4:0] != 5'd0) : (a[4:0] > 5'd28);
    err       = sp && !SPLIT_EN;
    exp_lat   = err ? 1 : ((wr ? 2 : 3) + (sp ? 1 : 0));
    exp_beats = err ? 0 : (sp ? 2 : 1);
    @(negedge clk);
    check("ready_idle", bus.req_ready, 1'b1);
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_vector = vec;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    beats.delete();
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.req_wdata = {8{$urandom}};
    lat = 1;
    while (!bus.rsp_valid && lat < 12) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, exp_lat);
    check("rsp_err", bus.rsp_err, err);
    check("beats", beats.size(), exp_beats);
    nwr = 0;
    foreach (beats[i]) if (beats[i].w) nwr++;
    check("beat_dir", nwr, wr ? beats.size() : 0);
    if (!err && !wr) last_load = ref_load(a, vec);
    if (!err && wr) ref_store(a, vec, wd, 32);
    check("rsp_rdata", bus.rsp_rdata, last_load);
    @(posedge clk);
    #1;
    check("rsp_pulse", bus.rsp_valid, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [V-1:0] pat;
    logic [N-1:0] a;
    bit wr, vec;

    for (int l = 0; l < LINES; l++) begin
      mem_lines[l] = {8{$urandom}};
      for (int k = 0; k < 32; k++) ref_mem[l*32 + k] = mem_lines[l][8*k +: 8];
    end
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_vector = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    last_load      = '0;
    rst = 1'b1;
    #1;
    check("rst_ready", bus.req_ready, 1'b1);
    check("rst_strobes", {bus.mem_rden, bus.mem_wren, bus.rsp_valid, bus.rsp_err}, 4'b0);
    check("rst_addr_be", {bus.mem_address, bus.mem_byteena}, 64'd0);
    check("rst_rdata", bus.rsp_rdata, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Aligned scalar store.
    do_req(1'b1, 1'b0, 32'h40, {224'd0, 32'hDEADBEEF});
    if (beats.size() >= 1) begin
      check("st_line", beats[0].a, 2);
      check("st_be", beats[0].be, 32'h0000_000F);
      check("st_data", beats[0].d[31:0], 32'hDEADBEEF);
    end

    // Aligned vector load of a known pattern.
    pat = {8{$urandom}};
    mem_lines[1] = pat;
    for (int k = 0; k < 32; k++) ref_mem[32 + k] = pat[8*k +: 8];
    do_req(1'b0, 1'b1, 32'h20, '0);
    check("vld_pattern", bus.rsp_rdata, pat);
    if (beats.size() >= 1) check("vld_line", beats[0].a, 1);

`ifdef MAU_SPLIT_ACCESS_EN
    do_req(1'b1, 1'b0, 32'h3E, {224'd0, 32'h11223344});
    if (beats.size() >= 2) begin
      check("sp_b0_line", beats[0].a, 1);
      check("sp_b0_be", beats[0].be, 32'hC000_0000);
      check("sp_b0_data", beats[0].d[255:240], 16'h3344);
      check("sp_b1_line", beats[1].a, 2);
      check("sp_b1_be", beats[1].be, 32'h0000_0003);
      check("sp_b1_data", beats[1].d[15:0], 16'h1122);
    end
`else
    do_req(1'b1, 1'b0, 32'h3E, {224'd0, 32'h11223344});
`endif

    // Split vector load, then a load wrapping past the top of the address space.
    do_req(1'b0, 1'b1, 32'h05, '0);
    do_req(1'b0, 1'b1, 32'hFFFF_FFF0, '0);
    do_req(1'b0, 1'b0, 32'hFFFF_FFFE, '0);

    for (int t = 0; t < 160; t++) begin
      wr  = 1'($urandom_range(0, 1));
      vec = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       a = 32'($urandom_range(0, LINES - 1) * 32);
        1:       a = 32'hFFFF_FFE0 | 32'($urandom_range(0, 31));
        default: a = 32'($urandom_range(0, BYTES - 1));
      endcase
      do_req(wr, vec, a, {8{$urandom}});
    end

    // Reset in the middle of a store.
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_vector = 1'b0;
`ifdef MAU_SPLIT_ACCESS_EN
    bus.req_addr   = 32'h7D;
`else
    bus.req_addr   = 32'h80;
`endif
    bus.req_wdata  = {224'd0, 32'hA1B2C3D4};
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
`ifdef MAU_SPLIT_ACCESS_EN
    @(posedge clk);
    ref_store(32'h7D, 1'b0, {224'd0, 32'hA1B2C3D4}, 3);
`endif
    @(negedge clk);
    check("mid_wren_before", bus.mem_wren, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_wren_after", bus.mem_wren, 1'b0);
    check("mid_ready", bus.req_ready, 1'b1);
    last_load = '0;
    @(negedge clk);
    rst = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 5; c++) begin
        @(posedge clk);
        #1;
        if (bus.rsp_valid) seen++;
      end
      check("mid_no_rsp", seen, 0);
    end
    do_req(1'b0, 1'b0, 32'h64, '0);

    repeat (2) @(posedge clk);
    for (int l = 0; l < LINES; l++) begin
      logic [V-1:0] exp_line;
      for (int k = 0; k < 32; k++) exp_line[8*k +: 8] = ref_mem[l*32 + k];
      check($sformatf("mem_line%0d", l), mem_lines[l], exp_line);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
